// File: rtl/div_pkg.sv
// ============================================================================
// Module : div_pkg
// Brief  : Shared types and sizing helpers for the shift/subtract divider.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } div_state_t;

    localparam int DIV_DW_DEFAULT = 16;

    function automatic int div_cnt_width(input int dw);
        return $clog2(dw + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// Module : div_step
// Brief  : One combinational restoring-division iteration (shift in, trial subtract).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module div_step #(
    parameter int DW = 16
) (
    input  logic [DW-1:0] r_in,
    input  logic          q_msb,
    input  logic [DW-1:0] divisor,
    output logic [DW-1:0] r_next,
    output logic          q_bit
);

    logic [DW:0] trial;

    // The partial remainder is always below the divisor, so its top bit is
    // zero and only the low DW bits need carrying between iterations.
    always_comb begin
        trial = {r_in, q_msb};
        q_bit = (trial >= {1'b0, divisor});
        if (q_bit) begin
            r_next = trial[DW-1:0] - divisor;
        end else begin
            r_next = trial[DW-1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/shift_sub_divider.sv
// ============================================================================
// Module : shift_sub_divider
// Brief  : Sequential unsigned restoring divider, one quotient bit per clock.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module shift_sub_divider
    import div_pkg::*;
#(
    parameter int DW = DIV_DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [DW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int            CW        = div_cnt_width(DW);
    localparam logic [CW-1:0] LAST_STEP = CW'(DW - 1);

    div_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] dvs_q, dvs_d;
    logic [DW-1:0] r_q, r_d;
    logic [DW-1:0] sh_q, sh_d;
    logic          zero_q, zero_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [DW-1:0] quot_q, quot_d;
    logic [DW-1:0] rem_q, rem_d;
    logic          dbz_q, dbz_d;

    logic [DW-1:0] step_r;
    logic          step_qbit;

    div_step #(
        .DW (DW)
    ) u_step (
        .r_in    (r_q),
        .q_msb   (sh_q[DW-1]),
        .divisor (dvs_q),
        .r_next  (step_r),
        .q_bit   (step_qbit)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvs_q   <= '0;
            r_q     <= '0;
            sh_q    <= '0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvs_q   <= dvs_d;
            r_q     <= r_d;
            sh_q    <= sh_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (divisor == '0) ? FIN : CALC;
                end
            end
            CALC: begin
                if (cnt_q == LAST_STEP) begin
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        dvs_d  = dvs_q;
        r_d    = r_q;
        sh_d   = sh_q;
        zero_d = zero_q;
        busy_d = busy_q;
        done_d = 1'b0;
        quot_d = quot_q;
        rem_d  = rem_q;
        dbz_d  = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dvs_d  = divisor;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                    dbz_d  = 1'b0;
                    // A zero divisor skips iteration; preload the fixed result
                    // so the finishing state publishes it like any other.
                    if (divisor == '0) begin
                        zero_d = 1'b1;
                        sh_d   = '1;
                        r_d    = dividend;
                    end else begin
                        zero_d = 1'b0;
                        sh_d   = dividend;
                        r_d    = '0;
                    end
                end
            end
            CALC: begin
                r_d   = step_r;
                sh_d  = {sh_q[DW-2:0], step_qbit};
                cnt_d = cnt_q + CW'(1);
            end
            FIN: begin
                quot_d = sh_q;
                rem_d  = r_q;
                dbz_d  = zero_q;
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_sub_divider.sv
// ============================================================================
// Module : tb_shift_sub_divider
// Brief  : Directed self-checking bench for the sequential divider.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_shift_sub_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;

    shift_sub_divider #(
        .DW (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Presents operands before edge E0, then scrambles them after capture.
    task automatic launch(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 16'hDEAD;
        divisor  = 16'h0BAD;
    endtask

    // Returns the edge number (relative to the last sampled edge) at which
    // done was seen, or -1 on timeout; optionally pulses start at inj_edge.
    task automatic wait_done(input int inj_edge, output int n, output int busy_lo);
        n       = -1;
        busy_lo = 0;
        for (int i = 1; i <= 40; i++) begin
            if (inj_edge > 0 && i == inj_edge) begin
                start    = 1'b1;
                dividend = 16'd1000;
                divisor  = 16'd3;
            end
            @(posedge clk);
            #1;
            if (inj_edge > 0 && i == inj_edge) start = 1'b0;
            if (done) begin
                n = i;
                break;
            end
            if (!busy) busy_lo++;
        end
    endtask

    int n, bl, dones;

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_quot", {16'd0, quotient}, 32'd0);
        check("rst_rem",  {16'd0, remainder}, 32'd0);
        check("rst_dbz",  {31'd0, div_by_zero}, 32'd0);
        rst = 1'b1;

        // 100/7
        launch(16'd100, 16'd7);
        check("t1_busy_e0", {31'd0, busy}, 32'd1);
        wait_done(0, n, bl);
        check("t1_lat",  n, 32'd17);
        check("t1_quot", {16'd0, quotient}, 32'd14);
        check("t1_rem",  {16'd0, remainder}, 32'd2);
        check("t1_dbz",  {31'd0, div_by_zero}, 32'd0);
        check("t1_busy_done", {31'd0, busy}, 32'd0);
        check("t1_busy_low_during", bl, 32'd0);
        @(posedge clk);
        #1;
        check("t1_done_pulse", {31'd0, done}, 32'd0);
        check("t1_quot_hold", {16'd0, quotient}, 32'd14);

        // FFFF/1 and 3/10
        launch(16'hFFFF, 16'd1);
        wait_done(0, n, bl);
        check("t2a_lat",  n, 32'd17);
        check("t2a_quot", {16'd0, quotient}, 32'hFFFF);
        check("t2a_rem",  {16'd0, remainder}, 32'd0);
        launch(16'd3, 16'd10);
        wait_done(0, n, bl);
        check("t2b_quot", {16'd0, quotient}, 32'd0);
        check("t2b_rem",  {16'd0, remainder}, 32'd3);

        // 5/0 then 9/3
        launch(16'd5, 16'd0);
        wait_done(0, n, bl);
        check("t3_lat",  n, 32'd1);
        check("t3_dbz",  {31'd0, div_by_zero}, 32'd1);
        check("t3_quot", {16'd0, quotient}, 32'hFFFF);
        check("t3_rem",  {16'd0, remainder}, 32'd5);
        launch(16'd9, 16'd3);
        check("t3_dbz_clear", {31'd0, div_by_zero}, 32'd0);
        wait_done(0, n, bl);
        check("t3b_quot", {16'd0, quotient}, 32'd3);
        check("t3b_rem",  {16'd0, remainder}, 32'd0);
        check("t3b_dbz",  {31'd0, div_by_zero}, 32'd0);

        // 50/6 with a start re-pulse at E5
        launch(16'd50, 16'd6);
        wait_done(5, n, bl);
        check("t4_lat",  n, 32'd17);
        check("t4_quot", {16'd0, quotient}, 32'd8);
        check("t4_rem",  {16'd0, remainder}, 32'd2);
        check("t4_busy_low_during", bl, 32'd0);
        dividend = '0;
        divisor  = '0;

        // reset at E8 of 200/9
        launch(16'd200, 16'd9);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_done", {31'd0, done}, 32'd0);
        check("t5_quot", {16'd0, quotient}, 32'd0);
        check("t5_rem",  {16'd0, remainder}, 32'd0);
        rst   = 1'b1;
        dones = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        check("t5_no_done", dones, 32'd0);
        launch(16'd200, 16'd9);
        wait_done(0, n, bl);
        check("t5b_lat",  n, 32'd17);
        check("t5b_quot", {16'd0, quotient}, 32'd22);
        check("t5b_rem",  {16'd0, remainder}, 32'd2);

        // start held high: 60/7 then 61/7 back-to-back
        @(negedge clk);
        dividend = 16'd60;
        divisor  = 16'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        dividend = 16'd61;
        wait_done(0, n, bl);
        check("t6a_lat",  n, 32'd17);
        check("t6a_quot", {16'd0, quotient}, 32'd8);
        check("t6a_rem",  {16'd0, remainder}, 32'd4);
        wait_done(0, n, bl);
        start = 1'b0;
        check("t6b_gap",  n, 32'd18);
        check("t6b_quot", {16'd0, quotient}, 32'd8);
        check("t6b_rem",  {16'd0, remainder}, 32'd5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
